// File: rtl/controller_bus_owner_sequencer.sv
// Arbitrates ownership of the shared PHY SCL/SDA lines between the I2C and I3C standby
// controllers. Ownership only changes hands across an idle bus, always via DRAIN -> OFF -> ARM.
module controller_bus_owner_sequencer #(
    parameter int unsigned DrainTimeout = 65535,
    parameter int unsigned CntWidth     = 20
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                i2c_standby_en_i,
    input  logic                i3c_standby_en_i,
    input  logic [CntWidth-1:0] t_bus_idle_i,
    input  logic                bus_scl_i,
    input  logic                bus_sda_i,
    input  logic                i2c_scl_i,
    input  logic                i2c_sda_i,
    input  logic                i2c_idle_i,
    input  logic                i3c_scl_i,
    input  logic                i3c_sda_i,
    input  logic                i3c_od_pp_i,
    input  logic                i3c_idle_i,
    output logic                scl_o,
    output logic                sda_o,
    output logic                phy_sel_od_pp_o,
    output logic                i2c_en_o,
    output logic                i3c_en_o,
    output logic [1:0]          owner_o,
    output logic                bus_idle_o,
    output logic                conflict_o,
    output logic                drain_timeout_o
);

    localparam logic [CntWidth-1:0] DrainMax = CntWidth'(DrainTimeout);
    localparam logic [1:0]          OwnNone  = 2'b00;
    localparam logic [1:0]          OwnI2c   = 2'b01;
    localparam logic [1:0]          OwnI3c   = 2'b10;

    typedef enum logic [2:0] {
        StOff   = 3'd0,
        StArm   = 3'd1,
        StI2c   = 3'd2,
        StI3c   = 3'd3,
        StDrain = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic [CntWidth-1:0] idle_cnt_q, idle_cnt_d;
    logic [CntWidth-1:0] drain_cnt_q, drain_cnt_d;
    logic [CntWidth-1:0] drain_cnt_inc;
    logic                bus_idle_q, bus_idle_d;
    logic                conflict_q;
    logic                drain_to_q, drain_to_d;
    logic                both_high;
    logic                owner_idle;
    logic [1:0]          target;

    assign both_high = bus_scl_i & bus_sda_i;

    // Consecutive-high counter, saturating at the programmed idle threshold
    always_comb begin
        idle_cnt_d = '0;
        if (both_high) begin
            if (idle_cnt_q >= t_bus_idle_i) begin
                idle_cnt_d = t_bus_idle_i;
            end else begin
                idle_cnt_d = idle_cnt_q + CntWidth'(1);
            end
        end
        bus_idle_d = both_high && (idle_cnt_d >= t_bus_idle_i);
    end

    // I3C wins when both standby modes are requested
    always_comb begin
        target = OwnNone;
        if (i3c_standby_en_i) begin
            target = OwnI3c;
        end else if (i2c_standby_en_i) begin
            target = OwnI2c;
        end
    end

    assign owner_idle    = (owner_q == OwnI3c) ? i3c_idle_i : i2c_idle_i;
    assign drain_cnt_inc = (drain_cnt_q >= DrainMax) ? drain_cnt_q : drain_cnt_q + CntWidth'(1);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        drain_cnt_d = '0;
        drain_to_d  = 1'b0;
        unique case (state_q)
            StOff: begin
                if (target != OwnNone) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                if (target == OwnNone) begin
                    state_d = StOff;
                end else if (bus_idle_q) begin
                    owner_d = target;
                    state_d = (target == OwnI3c) ? StI3c : StI2c;
                end
            end
            StI2c: begin
                if (!i2c_standby_en_i || i3c_standby_en_i) begin
                    state_d = StDrain;
                end
            end
            StI3c: begin
                if (!i3c_standby_en_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // A clean release wins over a timeout landing in the same cycle
                if (owner_idle && bus_idle_q) begin
                    state_d = StOff;
                    owner_d = OwnNone;
                end else begin
                    drain_cnt_d = drain_cnt_inc;
                    if (drain_cnt_inc >= DrainMax) begin
                        state_d    = StOff;
                        owner_d    = OwnNone;
                        drain_to_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StOff;
                owner_d = OwnNone;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StOff;
            owner_q     <= OwnNone;
            idle_cnt_q  <= '0;
            drain_cnt_q <= '0;
            bus_idle_q  <= 1'b0;
            conflict_q  <= 1'b0;
            drain_to_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            idle_cnt_q  <= idle_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            bus_idle_q  <= bus_idle_d;
            conflict_q  <= i2c_standby_en_i & i3c_standby_en_i;
            drain_to_q  <= drain_to_d;
        end
    end

    // Zero-latency pass-through of the owning controller's drives; owner_q is cleared in OFF/ARM
    always_comb begin
        scl_o           = 1'b1;
        sda_o           = 1'b1;
        phy_sel_od_pp_o = 1'b0;
        if (owner_q == OwnI2c) begin
            scl_o = i2c_scl_i;
            sda_o = i2c_sda_i;
        end else if (owner_q == OwnI3c) begin
            scl_o           = i3c_scl_i;
            sda_o           = i3c_sda_i;
            phy_sel_od_pp_o = i3c_od_pp_i;
        end
    end

    assign i2c_en_o        = (state_q == StI2c);
    assign i3c_en_o        = (state_q == StI3c);
    assign owner_o         = owner_q;
    assign bus_idle_o      = bus_idle_q;
    assign conflict_o      = conflict_q;
    assign drain_timeout_o = drain_to_q;

endmodule
